// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional registered reads,
// write-to-read bypass and a per-register busy scoreboard for multicycle producers.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  localparam int AW       = $clog2(DEPTH),
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int READ_REG = 0,
  parameter  int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     busy_set,
  input  logic [AW-1:0]            busy_addr,
  output logic                     busy_any
);

  logic [XLEN-1:0]        mem_q [DEPTH];
  logic [XLEN-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]       busy_q, busy_d;
  logic                   wr_ok, set_ok;
  logic [NUM_RD*XLEN-1:0] rd_val;

  // A write or busy mark aimed at the hardwired zero entry is dropped here,
  // so mem_q[0] and busy_q[0] never leave their reset value.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so the later conditional updates can never infer a latch.
    wr_ok  = reset_n && wr_en    && !(ZERO_REG != 0 && wr_addr   == '0);
    set_ok = reset_n && busy_set && !(ZERO_REG != 0 && busy_addr == '0);
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_d[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the register array is deliberately cleared by the synchronous
    // reset; software relies on every entry reading zero after reset.
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [AW-1:0] raddr;
    logic          fwd;
    logic          is_zero;
    rd_val  = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      raddr   = rd_addr[i*AW +: AW];
      fwd     = (BYPASS != 0) && wr_ok && (wr_addr == raddr);
      is_zero = (ZERO_REG != 0) && (raddr == '0);
      if (is_zero) begin
        rd_val[i*XLEN +: XLEN] = '0;
      end else if (fwd) begin
        rd_val[i*XLEN +: XLEN] = wr_data;
      end else begin
        rd_val[i*XLEN +: XLEN] = mem_q[raddr];
      end
      // A completing write hides the busy bit unless a new producer claims it.
      rd_busy[i] = busy_q[raddr] && !is_zero &&
                   !(fwd && !(set_ok && busy_addr == raddr));
    end
  end

  assign busy_any = |busy_q;

  if (READ_REG != 0) begin : g_read_reg
    logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_val;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data = rd_data_q;
  end else begin : g_read_comb
    assign rd_data = rd_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three 64-entry, 4-port configurations share
// stimulus (comb+bypass, registered+bypass, comb without bypass) against one array model.
module tb_regfile_mp;

  localparam int AW = 6;
  localparam int NR = 4;
  localparam int XL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [NR*AW-1:0] rd_addr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [XL-1:0]    wr_data;
  logic             busy_set;
  logic [AW-1:0]    busy_addr;

  logic [NR*XL-1:0] a_data, b_data, c_data;
  logic [NR-1:0]    a_busy, b_busy, c_busy;
  logic             a_any, b_any, c_any;

  regfile_mp #(.XLEN(XL), .DEPTH(64), .NUM_RD(NR), .ZERO_REG(1), .READ_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(a_data), .rd_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_any(a_any));

  regfile_mp #(.XLEN(XL), .DEPTH(64), .NUM_RD(NR), .ZERO_REG(1), .READ_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(b_data), .rd_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_any(b_any));

  regfile_mp #(.XLEN(XL), .DEPTH(64), .NUM_RD(NR), .ZERO_REG(1), .READ_REG(0), .BYPASS(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(c_data), .rd_busy(c_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_any(c_any));

  typedef struct packed {
    logic             chk;
    logic [NR*XL-1:0] a_d, b_d, c_d;
    logic [NR-1:0]    a_b, b_b, c_b;
    logic             any;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: architectural register contents and pending-producer flags.
  logic [XL-1:0] m_mem  [64];
  logic          m_busy [64];
  logic [XL-1:0] m_breg [NR];

  function automatic logic [XL-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && reset_n && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (!m_busy[a]) return 1'b0;
    if (byp && reset_n && wr_en && wr_addr == a && !(busy_set && busy_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NR*AW-1:0] ra4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic check(input string name, input logic [NR*XL-1:0] act, input logic [NR*XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit we, input int wa, input logic [XL-1:0] wd,
                       input bit bs, input int ba, input logic [NR*AW-1:0] ra, input bit chk);
    exp_t          e;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    reset_n   = rn;
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    busy_set  = bs;
    busy_addr = AW'(ba);
    rd_addr   = ra;
    e     = '0;
    e.chk = chk;
    for (int p = 0; p < NR; p++) begin
      a = ra[p*AW +: AW];
      e.a_d[p*XL +: XL] = exp_read(a, 1'b1);
      e.b_d[p*XL +: XL] = m_breg[p];
      e.c_d[p*XL +: XL] = exp_read(a, 1'b0);
      e.a_b[p] = exp_busy(a, 1'b1);
      e.b_b[p] = exp_busy(a, 1'b1);
      e.c_b[p] = exp_busy(a, 1'b0);
    end
    for (int r = 0; r < 64; r++) e.any |= m_busy[r];
    q.push_back(e);
    // Advance the model to the state after the coming rising edge.
    for (int p = 0; p < NR; p++) m_breg[p] = rn ? exp_read(ra[p*AW +: AW], 1'b1) : '0;
    if (!rn) begin
      for (int r = 0; r < 64; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (bs && ba != 0) m_busy[ba] = 1'b1;
    end
  endtask

  task automatic idle_read(input logic [NR*AW-1:0] ra);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, ra, 1'b1);
  endtask

  // Monitor: compares whatever the DUTs present mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("a_rd_data", a_data, e.a_d);
          check("b_rd_data", b_data, e.b_d);
          check("c_rd_data", c_data, e.c_d);
          check("a_rd_busy", (NR*XL)'(a_busy), (NR*XL)'(e.a_b));
          check("b_rd_busy", (NR*XL)'(b_busy), (NR*XL)'(e.b_b));
          check("c_rd_busy", (NR*XL)'(c_busy), (NR*XL)'(e.c_b));
          check("a_busy_any", (NR*XL)'(a_any), (NR*XL)'(e.any));
          check("b_busy_any", (NR*XL)'(b_any), (NR*XL)'(e.any));
          check("c_busy_any", (NR*XL)'(c_any), (NR*XL)'(e.any));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; rd_addr = '0;
    for (int r = 0; r < 64; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int p = 0; p < NR; p++) m_breg[p] = '0;

    // Power-up: outputs undefined until the first reset edge.
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
    idle_read(ra4(5, 9, 63, 1));

    // Reset clear, including a write and busy mark issued during reset.
    cycle(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, ra4(5, 5, 5, 5), 1'b1);
    idle_read(ra4(5, 5, 5, 5));
    cycle(1'b0, 1'b1, 5, 32'h0BAD0BAD, 1'b1, 9, ra4(0, 0, 0, 0), 1'b1);
    idle_read(ra4(5, 9, 5, 9));
    idle_read(ra4(5, 9, 5, 9));

    // x0 hardwiring.
    cycle(1'b1, 1'b1, 0, 32'h12345678, 1'b1, 0, ra4(0, 0, 0, 0), 1'b1);
    idle_read(ra4(0, 0, 0, 0));
    idle_read(ra4(0, 0, 0, 0));

    // Same-cycle bypass of a rewrite.
    cycle(1'b1, 1'b1, 7, 32'h11, 1'b0, 0, ra4(1, 2, 3, 4), 1'b1);
    cycle(1'b1, 1'b1, 7, 32'h22, 1'b0, 0, ra4(7, 7, 1, 1), 1'b1);
    idle_read(ra4(7, 7, 7, 7));

    // Registered read timing and bypass into the sampling cycle.
    cycle(1'b1, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, ra4(0, 0, 0, 0), 1'b1);
    idle_read(ra4(0, 3, 0, 0));
    cycle(1'b1, 1'b1, 3, 32'h5A5A5A5A, 1'b0, 0, ra4(0, 3, 0, 0), 1'b1);
    idle_read(ra4(0, 0, 0, 0));
    idle_read(ra4(3, 3, 0, 0));

    // Scoreboard set, clear-by-write, and set-wins collision.
    cycle(1'b1, 1'b0, 0, '0, 1'b1, 9, ra4(9, 9, 0, 1), 1'b1);
    idle_read(ra4(9, 0, 9, 2));
    cycle(1'b1, 1'b1, 9, 32'h99, 1'b0, 0, ra4(9, 9, 9, 9), 1'b1);
    idle_read(ra4(9, 9, 9, 9));
    cycle(1'b1, 1'b0, 0, '0, 1'b1, 9, ra4(9, 9, 9, 9), 1'b1);
    cycle(1'b1, 1'b1, 9, 32'h1234, 1'b1, 9, ra4(9, 9, 9, 9), 1'b1);
    idle_read(ra4(9, 9, 9, 9));
    cycle(1'b1, 1'b1, 9, 32'h4321, 1'b1, 10, ra4(9, 10, 9, 10), 1'b1);
    idle_read(ra4(9, 10, 9, 10));

    // Top entry on all ports, then distinct addresses per port.
    cycle(1'b1, 1'b1, 63, 32'hFFFFFFFF, 1'b0, 0, ra4(63, 63, 63, 63), 1'b1);
    idle_read(ra4(63, 63, 63, 63));
    for (int r = 1; r <= 4; r++) begin
      cycle(1'b1, 1'b1, r, 32'h1000_0000 * r + r, 1'b0, 0, ra4(63, 0, 0, 0), 1'b1);
    end
    idle_read(ra4(1, 2, 3, 4));
    idle_read(ra4(4, 3, 2, 1));

    // Randomized traffic, biased to a few registers so collisions are frequent.
    for (int n = 0; n < 800; n++) begin
      int            wa, ba;
      logic [NR*AW-1:0] ra;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      ba = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      for (int p = 0; p < NR; p++) begin
        ra[p*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      end
      cycle(1'b1, 1'($urandom_range(0, 1)), wa, $urandom(), 1'($urandom_range(0, 3) == 0), ba, ra, 1'b1);
    end

    idle_read(ra4(0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, two-read RV32I register file.
- Sits between decode (read ports) and writeback (write port) of the single-cycle/pipelined core.
- Adds a true clock, synchronous reset and configurable read-port count and depth. Also adds optional registered reads, write-to-read bypass and a per-register busy scoreboard for multicycle producers (loads, future mul/div).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, 2..64.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, is never busy.
- READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  port i's addressed register has a pending producer.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- busy_set  in  1  mark busy_addr as pending (issue of multicycle op).
- busy_addr  in  AW  register to mark busy.
- busy_any  out  1  OR of all busy bits (pipeline drain / flush checks).

Behaviour:
- Reset: reset_n=0 at posedge clk clears all DEPTH entries, all busy bits and (READ_REG=1) the rd_data registers to 0. wr_en and busy_set are ignored in that cycle. Reset is synchronous only; no asynchronous path.
- After reset, rd_data=0, rd_busy=0, busy_any=0.
- Write: wr_en=1 at posedge clk, with reset_n=1, stores wr_data into entry wr_addr. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Write also clears busy[wr_addr].
- READ_REG=0: rd_data[i] = entry[rd_addr[i]] combinationally.
  - BYPASS=1 and wr_en and wr_addr==rd_addr[i] (and not the dropped x0 case): rd_data[i] = wr_data in the same cycle.
  - BYPASS=0: old value until the edge.
- READ_REG=1: rd_addr sampled at posedge; rd_data valid the cycle after.
  - BYPASS=1: a write to the same address in the sampling cycle returns the new wr_data.
  - BYPASS=0: returns the pre-write value.
- Zero register: ZERO_REG=1 means rd_addr=0 always yields 0 and rd_busy=0, regardless of bypass or busy_set.
- Scoreboard: busy_set=1 at posedge sets busy[busy_addr]. Ignored for addr 0 when ZERO_REG=1.
  - Same edge, busy_set and wr_en to the same address: set wins, and the data is still written. The new producer supersedes the completing one.
  - Different addresses: both take effect.
- rd_busy[i] = busy[rd_addr[i]], combinational in both READ_REG modes, reflecting the current address. It does not include same-cycle busy_set.
  - Same-cycle clear bypass: BYPASS=1 and wr_en to that address with no same-address busy_set gives rd_busy[i]=0 in that cycle.
- busy_any = |busy, registered state only.
- Multiple read ports on the same address return identical data and busy.
- No out-of-range addresses are possible (DEPTH = 2^AW).

Test Plan:
1. Reset clear: write 0xDEADBEEF to x5. Assert reset_n=0 for one cycle. Read x5 -> 0, busy_any=0. Write issued in the reset cycle is not stored.
2. x0 hardwiring (ZERO_REG=1): wr_en, addr 0, data 0x12345678; busy_set addr 0 -> read x0 = 0, rd_busy=0, busy_any=0.
3. Bypass (READ_REG=0, BYPASS=1): x7=0x11, then same-cycle write x7=0x22 with rd_addr[0]=7 -> rd_data=0x22 before the edge. With BYPASS=0 -> 0x11 before the edge, 0x22 after.
4. Registered read (READ_REG=1): rd_addr[1]=3 with x3=0xA5A5A5A5 -> rd_data[1]=0xA5A5A5A5 exactly one cycle later. A same-cycle write of 0x5A5A5A5A to x3 with BYPASS=1 returns 0x5A5A5A5A.
5. Scoreboard:
   - busy_set x9 -> next cycle rd_busy=1 on a port reading x9, busy_any=1.
   - wr_en x9=0x99 -> same-cycle rd_busy=0 (BYPASS=1); after the edge busy_any=0, data 0x99.
   - Simultaneous busy_set and wr_en on x9 -> stays busy, data updated.
6. Four ports (NUM_RD=4, DEPTH=64): all ports read x63 after writing 0xFFFFFFFF -> all four return 0xFFFFFFFF. Mixed addresses 1/2/3/4 each return their own distinct values.
